// File: rtl/ro_sb_pkg.sv
// Shared constants and helpers for the read-operands pending-write scoreboard.
// Register-file geometry, implicit source indices and the register-class encoding.
package ro_sb_pkg;

    localparam int NREG   = 8;
    localparam int NCLASS = 3;

    localparam logic [2:0] REG_EAX = 3'h0;
    localparam logic [2:0] REG_ECX = 3'h1;

    typedef enum logic [1:0] {
        RC_GPR = 2'd0,
        RC_MMX = 2'd1,
        RC_SEG = 2'd2
    } reg_class_e;

    // A slot that is not valid contributes nothing; OR-ing slots collapses duplicates.
    function automatic logic [NREG-1:0] reg_onehot(input logic [2:0] idx, input logic vld);
        logic [NREG-1:0] oh;
        oh = '0;
        if (vld) oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ro_scoreboard_if.sv
// RO-stage source, issue/retire/flush and status bundle for the scoreboard.
// master drives the pipeline side; slave is the scoreboard itself.
interface ro_scoreboard_if #(
    parameter int PERF_W = 16
);
    logic              V_ro;
    logic [2:0]        in3, in4;
    logic              in3_needed, in4_needed;
    logic              eax_needed, ecx_needed;
    logic [2:0]        mm1, mm2;
    logic              mm1_needed, mm2_needed;
    logic [2:0]        seg3;
    logic              seg3_needed;

    logic              issue;
    logic [2:0]        iss_dreg1, iss_dreg2, iss_dreg3;
    logic              iss_ld_reg1, iss_ld_reg2, iss_ld_reg3;
    logic [2:0]        iss_dmm;
    logic              iss_ld_mm;
    logic [2:0]        iss_dseg;
    logic              iss_ld_seg;

    logic              retire;
    logic [2:0]        ret_dreg1, ret_dreg2, ret_dreg3;
    logic              ret_ld_reg1, ret_ld_reg2, ret_ld_reg3;
    logic [2:0]        ret_dmm;
    logic              ret_ld_mm;
    logic [2:0]        ret_dseg;
    logic              ret_ld_seg;

    logic              flush;

    logic              dep_stall;
    logic              busy;
    logic              sb_err;
    logic [PERF_W-1:0] dep_stall_cnt;

    modport master (
        output V_ro, in3, in4, in3_needed, in4_needed, eax_needed, ecx_needed,
               mm1, mm2, mm1_needed, mm2_needed, seg3, seg3_needed,
               issue, iss_dreg1, iss_dreg2, iss_dreg3, iss_ld_reg1, iss_ld_reg2, iss_ld_reg3,
               iss_dmm, iss_ld_mm, iss_dseg, iss_ld_seg,
               retire, ret_dreg1, ret_dreg2, ret_dreg3, ret_ld_reg1, ret_ld_reg2, ret_ld_reg3,
               ret_dmm, ret_ld_mm, ret_dseg, ret_ld_seg, flush,
        input  dep_stall, busy, sb_err, dep_stall_cnt
    );

    modport slave (
        input  V_ro, in3, in4, in3_needed, in4_needed, eax_needed, ecx_needed,
               mm1, mm2, mm1_needed, mm2_needed, seg3, seg3_needed,
               issue, iss_dreg1, iss_dreg2, iss_dreg3, iss_ld_reg1, iss_ld_reg2, iss_ld_reg3,
               iss_dmm, iss_ld_mm, iss_dseg, iss_ld_seg,
               retire, ret_dreg1, ret_dreg2, ret_dreg3, ret_ld_reg1, ret_ld_reg2, ret_ld_reg3,
               ret_dmm, ret_ld_mm, ret_dseg, ret_ld_seg, flush,
        output dep_stall, busy, sb_err, dep_stall_cnt
    );

endinterface

// File: rtl/sb_cnt_bank.sv
// Bank of NREG saturating pending-write counters; inc/dec one-hot, clr wins over both.
// Updates land one cycle later; nz is straight from state; err is a same-cycle over/underflow pulse.
module sb_cnt_bank
    import ro_sb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [NREG-1:0] inc,
    input  logic [NREG-1:0] dec,
    output logic [NREG-1:0] nz,
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [NREG-1:0]  ovf;
    logic [NREG-1:0]  unf;

    // Simultaneous inc and dec on one counter cancel and can never fault.
    always_comb begin
        nz  = '0;
        ovf = '0;
        unf = '0;
        for (int i = 0; i < NREG; i++) begin
            nz[i]  = (cnt_q[i] != '0);
            ovf[i] = !clr && inc[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
            unf[i] = !clr && dec[i] && !inc[i] && (cnt_q[i] == '0);
        end
    end

    assign err = |{ovf, unf};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc[i] && !dec[i] && !ovf[i])
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                else if (dec[i] && !inc[i] && !unf[i])
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ro_scoreboard.sv
// Pending-write scoreboard for RO: per-register counters raised on RO->EX, lowered on WB retire.
// dep_stall is combinational from registered counts (no retire bypass); stalls RO issue, never the back end.
module ro_scoreboard
    import ro_sb_pkg::*;
#(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    ro_scoreboard_if.slave sb
);

    logic [NCLASS-1:0][NREG-1:0] inc_v;
    logic [NCLASS-1:0][NREG-1:0] dec_v;
    logic [NCLASS-1:0][NREG-1:0] nz_v;
    logic [NCLASS-1:0]           bank_err;
    logic                        src_hit;
    logic                        stall;
    logic                        proto_err;
    logic                        err_q;
    logic [PERF_W-1:0]           perf_q;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (sb.issue) begin
            inc_v[RC_GPR] = reg_onehot(sb.iss_dreg1, sb.iss_ld_reg1)
                          | reg_onehot(sb.iss_dreg2, sb.iss_ld_reg2)
                          | reg_onehot(sb.iss_dreg3, sb.iss_ld_reg3);
            inc_v[RC_MMX] = reg_onehot(sb.iss_dmm, sb.iss_ld_mm);
            inc_v[RC_SEG] = reg_onehot(sb.iss_dseg, sb.iss_ld_seg);
        end
        if (sb.retire) begin
            dec_v[RC_GPR] = reg_onehot(sb.ret_dreg1, sb.ret_ld_reg1)
                          | reg_onehot(sb.ret_dreg2, sb.ret_ld_reg2)
                          | reg_onehot(sb.ret_dreg3, sb.ret_ld_reg3);
            dec_v[RC_MMX] = reg_onehot(sb.ret_dmm, sb.ret_ld_mm);
            dec_v[RC_SEG] = reg_onehot(sb.ret_dseg, sb.ret_ld_seg);
        end
    end

    // flush clears every bank and masks the bank fault outputs for that cycle.
    for (genvar c = 0; c < NCLASS; c++) begin : g_bank
        sb_cnt_bank #(
            .CNT_W (CNT_W)
        ) u_bank (
            .clk (clk),
            .rst (rst),
            .clr (sb.flush),
            .inc (inc_v[c]),
            .dec (dec_v[c]),
            .nz  (nz_v[c]),
            .err (bank_err[c])
        );
    end

    always_comb begin
        src_hit = (sb.in3_needed  && nz_v[RC_GPR][sb.in3])
               || (sb.in4_needed  && nz_v[RC_GPR][sb.in4])
               || (sb.eax_needed  && nz_v[RC_GPR][REG_EAX])
               || (sb.ecx_needed  && nz_v[RC_GPR][REG_ECX])
               || (sb.mm1_needed  && nz_v[RC_MMX][sb.mm1])
               || (sb.mm2_needed  && nz_v[RC_MMX][sb.mm2])
               || (sb.seg3_needed && nz_v[RC_SEG][sb.seg3]);
    end

    assign stall     = sb.V_ro && src_hit;
    assign proto_err = sb.issue && stall && !sb.flush;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if ((|bank_err) || proto_err)
            err_q <= 1'b1;
    end

    // Perf count keeps running across flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst)
            perf_q <= '0;
        else if (stall && (perf_q != '1))
            perf_q <= perf_q + PERF_W'(1);
    end

    assign sb.dep_stall     = stall;
    assign sb.busy          = |nz_v;
    assign sb.sb_err        = err_q;
    assign sb.dep_stall_cnt = perf_q;

endmodule

// File: doc/ro_scoreboard.md
Name: ro_scoreboard

Overview:
- Pending-write scoreboard for the read-operands stage: tracks in-flight writes to the 8 GPRs, 8 MMX registers and 8 segment registers.
- Replaces per-stage destination comparators with per-register counters. Counters increment when an instruction leaves RO into EX and decrement when it retires out of WB.
- Produces dep_stall for the RO source operands, plus a saturating stall-cycle counter and a sticky consistency-error flag.

Parameters:
CNT_W, 2, width of each pending-write counter (max 3 in flight per register)
PERF_W, 16, width of the dep-stall cycle counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
V_ro  in  1  RO stage holds a valid instruction
in3, in4  in  3 each  GPR source specifiers
in3_needed, in4_needed  in  1 each  source qualifiers
eax_needed, ecx_needed  in  1 each  implicit GPR 0 / GPR 1 sources
mm1, mm2  in  3 each  MMX source specifiers
mm1_needed, mm2_needed  in  1 each  qualifiers
seg3  in  3  segment source
seg3_needed  in  1  qualifier
issue  in  1  instruction moves RO->EX this cycle (V_ex && ld_ex)
iss_dreg1, iss_dreg2, iss_dreg3  in  3 each  GPR destinations of issuing instruction
iss_ld_reg1, iss_ld_reg2, iss_ld_reg3  in  1 each  destination valids
iss_dmm  in  3  MMX destination
iss_ld_mm  in  1  valid
iss_dseg  in  3  segment destination
iss_ld_seg  in  1  valid
retire  in  1  instruction leaves WB this cycle with its writes committed
ret_dreg1..3, ret_ld_reg1..3, ret_dmm, ret_ld_mm, ret_dseg, ret_ld_seg  in  3/1  as issue side
flush  in  1  squash of all post-RO instructions
dep_stall  out  1  RO must not issue
busy  out  1  any counter nonzero
sb_err  out  1  sticky over/underflow flag
dep_stall_cnt  out  PERF_W  cycles with dep_stall high, saturating

Behaviour:
- Reset (sync, rst=1): all counters = 0; sb_err = 0; dep_stall_cnt = 0. With counters at 0, dep_stall = 0 and busy = 0.
- Per-instruction set semantics:
  - A GPR is "written" by an instruction if any valid slot (1..3) names it. Duplicate slots count once.
  - MMX and segment registers follow the same rule with their single slot.
  - Issue increments each written register's counter by 1. Retire decrements by 1.
- Issue and retire touching the same register in the same cycle: net 0 change, no error.
- Counter updates are registered. A register issued in cycle N shows as pending from cycle N+1.
- dep_stall is combinational from the current counters, gated by V_ro. It is high if any qualified source has counter != 0:
  - GPR sources: in3, in4, GPR 0 if eax_needed, GPR 1 if ecx_needed.
  - MMX sources: mm1, mm2.
  - Segment source: seg3.
- No same-cycle bypass: a retire in cycle N clears the stall only from cycle N+1.
- issue while dep_stall=1 is a protocol violation: set sb_err, but still perform the increment.
- Overflow (increment at max count): counter holds at max and sb_err is set.
- Underflow (decrement at 0): counter holds at 0 and sb_err is set.
- sb_err clears only on rst.
- flush:
  - Zeroes all counters next cycle.
  - Takes priority over a same-cycle issue or retire; both are ignored and no error is flagged.
  - Upstream guarantees WB retirement is complete or also squashed when flush is asserted.
- busy = OR of all counters != 0 (registered-state derived, combinational out).
- dep_stall_cnt increments each cycle dep_stall=1, saturates at all-ones, and is unaffected by flush.

Decomposition:
- Package ro_sb_pkg holds:
  - REG_EAX = 3'h0 and REG_ECX = 3'h1.
  - Register-file size constant NREG = 8.
  - Register-class enum: GPR, MMX, SEG.
- One sub-module, sb_cnt_bank: NREG counters of CNT_W bits.
  - Inputs: inc one-hot, dec one-hot, clr.
  - Outputs: nonzero vector and per-bank err.
  - Instantiated three times (GPR, MMX, SEG). The top does decoding, source lookup, error OR and the perf counter.

Test Plan:
- Reset, then V_ro=1 with in3=2 needed -> dep_stall=0, busy=0, dep_stall_cnt=0.
- Issue with iss_dreg1=2 valid; next cycle V_ro=1, in3=2 needed -> dep_stall=1. Retire ret_dreg1=2 -> dep_stall=0 the cycle after the retire, dep_stall_cnt=count of stalled cycles.
- Issue with iss_dreg1=iss_dreg2=5 both valid, then one retire naming 5 once -> counter back to 0, sb_err=0. Same-cycle issue and retire of reg 3 while its count=1 -> count stays 1.
- eax_needed=1 with GPR0 pending; then ecx_needed with GPR1 pending; seg3=4 with iss_dseg=4; mm2=7 with iss_dmm=7 -> dep_stall=1 in each case. With the needed bits low -> dep_stall=0.
- Three issues to reg 6 -> count 3. A fourth issue -> count holds at 3, sb_err=1. Retire on an idle register -> sb_err stays 1.
- Two registers pending, then flush together with an issue -> next cycle busy=0, dep_stall=0, no sb_err. Assert rst mid-stall -> all outputs return to reset values the following cycle.
